// File: rtl/mac_rr_arbiter_pkg.sv
// mac_pkg: shared constants, result-stage state type and round-robin pick helper
//   DATA_PATH_BITWIDTH_DEF : default operand/result width
//   st_e                   : result-stage state {ST_EMPTY, ST_FULL}
//   rr_pick(valid,ptr,n)   : first set index scanning from ptr modulo n, -1 if none
package mac_pkg;
    localparam int DATA_PATH_BITWIDTH_DEF = 16;
    typedef enum logic {ST_EMPTY, ST_FULL} st_e;
    function automatic int rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        int r;
        logic [2:0] idx;
        r = -1;
        for (int k = 0; k < 8; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && r < 0 && valid[idx]) r = int'(idx);
        end
        return r;
    endfunction
endpackage

// File: rtl/mac_rr_arbiter_if.sv
// mac_rr_arbiter_if: request/result handshake bundle between clients and the shared MAC
//   req_valid/req_ready : per-requester handshake, req_a/b/c packed operands (slice i = requester i)
//   res_valid/res_ready : result handshake, res_id/res_data tagged result
//   master = client side, slave = arbiter side
interface mac_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W = 16,
    parameter int ID_W = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*W-1:0] req_c;
    logic               res_valid;
    logic               res_ready;
    logic [ID_W-1:0]    res_id;
    logic [W-1:0]       res_data;
    modport master (
        output req_valid, req_a, req_b, req_c, res_ready,
        input  req_ready, res_valid, res_id, res_data
    );
    modport slave (
        input  req_valid, req_a, req_b, req_c, res_ready,
        output req_ready, res_valid, res_id, res_data
    );
endinterface

// File: rtl/mac_rr_arbiter_dp.sv
// mac_dp: combinational unsigned W-bit multiply-accumulate d = (a*b mod 2^W) + c mod 2^W
//   a_i, b_i, c_i : operands; d_o : result
module mac_dp #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] d_o
);
    // A W-bit product is exactly the low W bits of the full 2W product
    assign d_o = a_i * b_i + c_i;
endmodule

// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter: round-robin arbiter sharing one MAC among N_REQ requesters, 1-deep tagged result stage
//   clk, rst : clock, async active-high reset
//   bus      : mac_rr_arbiter_if.slave (request handshakes in, tagged result out)
//   op_cnt, busy_cnt : result-handshake and stall counters, present only with MAC_RR_ARBITER_OPCNT_EN
module mac_rr_arbiter
    import mac_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DATA_PATH_BITWIDTH_DEF,
    parameter int N_REQ = 4,
    parameter int ID_W = 2
) (
    input  logic clk,
    input  logic rst,
    mac_rr_arbiter_if.slave bus
`ifdef MAC_RR_ARBITER_OPCNT_EN
    ,
    output logic [15:0] op_cnt,
    output logic [15:0] busy_cnt
`endif
);
    localparam int W = DATA_PATH_BITWIDTH;
    st_e             state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, id_q, sel;
    logic [W-1:0]    data_q, mac_d;
    logic            grant;
    int              pick;
    // Grant only when the result slot is free or being drained this cycle; held off during reset
    always_comb begin
        pick = rr_pick(8'(bus.req_valid), 3'(ptr_q), N_REQ);
        grant = !rst && (state_q == ST_EMPTY || bus.res_ready) && pick >= 0;
        sel = pick < 0 ? '0 : ID_W'(pick);
        ptr_d = !grant ? ptr_q : (int'(sel) == N_REQ - 1 ? '0 : sel + 1'b1);
    end
    assign bus.req_ready = grant ? N_REQ'(1) << sel : '0;
    mac_dp #(.W(W)) u_dp (
        .a_i(bus.req_a[int'(sel)*W +: W]),
        .b_i(bus.req_b[int'(sel)*W +: W]),
        .c_i(bus.req_c[int'(sel)*W +: W]),
        .d_o(mac_d)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end
    always_comb state_d = grant ? ST_FULL : (bus.res_ready ? ST_EMPTY : state_q);
    always_comb bus.res_valid = state_q == ST_FULL;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                id_q   <= sel;
                data_q <= mac_d;
            end
        end
    end
    assign bus.res_id   = id_q;
    assign bus.res_data = data_q;
`ifdef MAC_RR_ARBITER_OPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt   <= '0;
            busy_cnt <= '0;
        end else begin
            if (bus.res_valid && bus.res_ready) op_cnt <= op_cnt + 1'b1;
            if (bus.res_valid && !bus.res_ready && busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mac_rr_arbiter.sv
// tb_mac_rr_arbiter: directed + randomized bench against a transaction-level model of the arbiter
module tb_mac_rr_arbiter;
    localparam int W = 16, N = 4, IDW = 2;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    mac_rr_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IDW)) bus ();
`ifdef MAC_RR_ARBITER_OPCNT_EN
    logic [15:0] op_cnt, busy_cnt;
    mac_rr_arbiter #(.DATA_PATH_BITWIDTH(W), .N_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .op_cnt(op_cnt), .busy_cnt(busy_cnt));
`else
    mac_rr_arbiter #(.DATA_PATH_BITWIDTH(W), .N_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif
    logic [W-1:0] a [N], b [N], c [N];
    logic [N-1:0] v = '0;
    logic         rr = 0;
    for (genvar i = 0; i < N; i++) begin : g_drv
        assign bus.req_a[i*W +: W] = a[i];
        assign bus.req_b[i*W +: W] = b[i];
        assign bus.req_c[i*W +: W] = c[i];
    end
    assign bus.req_valid = v;
    assign bus.res_ready = rr;

    int checks = 0, failures = 0;
    int mptr = 0, mid = 0, last_g = -1;
    bit mvalid = 0;
    logic [W-1:0] mdata = '0;

    function automatic logic [W-1:0] mac(input logic [W-1:0] x, y, z);
        longint unsigned p;
        p = (longint'(x) * longint'(y)) % 65536;
        return W'((p + longint'(z)) % 65536);
    endfunction

    function automatic int winner(input logic [N-1:0] vv, input int from);
        for (int k = 0; k < N; k++)
            if (vv[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already set; checks then advances one clock
    task automatic cycle(input string tag);
        int g;
        logic [N-1:0] em;
        #1;
        g = (mvalid && !rr) ? -1 : winner(v, mptr);
        em = (g < 0) ? '0 : N'(1) << g;
        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(em));
        chk({tag, ".res_valid"}, 64'(bus.res_valid), 64'(mvalid));
        if (mvalid) begin
            chk({tag, ".res_id"}, 64'(bus.res_id), 64'(mid));
            chk({tag, ".res_data"}, 64'(bus.res_data), 64'(mdata));
        end
        @(posedge clk);
        if (g >= 0) begin
            mvalid = 1;
            mid = g;
            mdata = mac(a[g], b[g], c[g]);
            mptr = (g + 1) % N;
        end else if (rr) mvalid = 0;
        last_g = g;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; c[i] = '0; end
        repeat (2) @(negedge clk);
        chk("rst.res_valid", 64'(bus.res_valid), 0);
        chk("rst.res_id", 64'(bus.res_id), 0);
        chk("rst.res_data", 64'(bus.res_data), 0);
        chk("rst.req_ready", 64'(bus.req_ready), 0);
`ifdef MAC_RR_ARBITER_OPCNT_EN
        chk("rst.op_cnt", 64'(op_cnt), 0);
`endif
        rst = 0;
        rr = 1;
        repeat (10) cycle("idle");
        a[0] = 3; b[0] = 5; c[0] = 7; v = 4'b0001;
        cycle("single.req");
        v = '0;
        cycle("single.res");
        chk("single.data22", 64'(bus.res_data), 64'd22);
        a[3] = 9; b[3] = 9; c[3] = 9; v = 4'b1000;
        cycle("ptr_to0");
        v = '0;
        cycle("ptr_to0.res");
        for (int i = 0; i < N; i++) begin
            a[i] = W'(100 + i); b[i] = W'(7 * i + 3); c[i] = W'(1000 * i);
        end
        v = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle("contend");
            chk("contend.order", 64'(last_g), 64'(k % N));
        end
        v = 4'b0100; a[2] = 16'h1234; b[2] = 16'h0011; c[2] = 16'h0F0F; rr = 0;
        repeat (5) cycle("bp.hold");
        rr = 1;
        cycle("bp.release");
        chk("bp.granted2", 64'(last_g), 2);
        v = '0;
        cycle("bp.res");
        cycle("bp.drain");
        a[1] = 16'hFFFF; b[1] = 16'h0002; c[1] = 16'h0003; v = 4'b0010;
        cycle("wrap1.req");
        v = '0;
        cycle("wrap1.res");
        chk("wrap1.data", 64'(bus.res_data), 64'h0001);
        a[1] = 16'h0100; b[1] = 16'h0100; c[1] = 16'hFFFF; v = 4'b0010;
        cycle("wrap2.req");
        v = '0;
        cycle("wrap2.res");
        chk("wrap2.data", 64'(bus.res_data), 64'hFFFF);
        a[0] = 16'h0042; b[0] = 16'h0003; c[0] = 16'h0001; v = 4'b0001; rr = 0;
        cycle("arst.fill");
        v = '0;
        #2 rst = 1;
        #1;
        chk("arst.res_valid", 64'(bus.res_valid), 0);
        chk("arst.res_data", 64'(bus.res_data), 0);
`ifdef MAC_RR_ARBITER_OPCNT_EN
        chk("arst.op_cnt", 64'(op_cnt), 0);
`endif
        mvalid = 0; mptr = 0; mid = 0; mdata = '0;
        @(negedge clk);
        rst = 0; rr = 1;
        a[3] = 16'h0777; b[3] = 16'h0010; c[3] = 16'h0005; v = 4'b1000;
        cycle("arst.req3");
        chk("arst.granted3", 64'(last_g), 3);
        v = '0;
        cycle("arst.res3");
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (i == last_g) v[i] = $urandom_range(0, 1) == 1;
                else if (!v[i]) v[i] = $urandom_range(0, 4) < 2;
                if (i == last_g || !v[i]) begin
                    a[i] = W'($urandom); b[i] = W'($urandom); c[i] = W'($urandom);
                end
            end
            rr = $urandom_range(0, 3) != 0;
            cycle("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
